// File: rtl/ssb_gen_pkg.sv
// Shared constants, LFSR tap masks/init vectors and FSM state type for the
// SSB generator.
package ssb_gen_pkg;

  localparam int SSB_SC     = 240;
  localparam int SEQ_LEN    = 127;
  localparam int SEQ_START  = 56;
  localparam int N_ID_1_MAX = 335;

  // Bit j of a mask/init vector corresponds to x(i+j); bit 0 is the output bit.
  localparam logic [6:0] PSS_TAPS  = 7'b0010001;
  localparam logic [6:0] PSS_INIT  = 7'b1110110;
  localparam logic [6:0] SSS0_TAPS = 7'b0010001;
  localparam logic [6:0] SSS0_INIT = 7'b0000001;
  localparam logic [6:0] SSS1_TAPS = 7'b0000011;
  localparam logic [6:0] SSS1_INIT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GEN    = 2'd1,
    ST_STREAM = 2'd2
  } ssb_state_e;

  function automatic logic [6:0] mod127(input logic [7:0] s);
    logic [7:0] d;
    d = s - 8'd127;
    return (s >= 8'd127) ? d[6:0] : s[6:0];
  endfunction

endpackage

// File: rtl/m_seq_lfsr.sv
// 7-bit Fibonacci LFSR producing one m-sequence bit x(i) per enabled cycle.
module m_seq_lfsr #(
  parameter logic [6:0] TAPS = 7'b0010001,
  parameter logic [6:0] INIT = 7'b0000001
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_bit
);

  logic [6:0] r_state;
  logic       w_fb;

  assign w_fb  = ^(r_state & TAPS);
  assign o_bit = r_state[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= INIT;
    end else if (i_load) begin
      r_state <= INIT;
    end else if (i_en) begin
      r_state <= {w_fb, r_state[6:1]};
    end
  end

endmodule

// File: rtl/ssb_sync_gen.sv
// NR SSB PSS/SSS frequency-domain generator, streamed in FFT-bin order.
// SSB_GEN_FULL_BLOCK_EN adds all-zero PBCH symbols 1 and 3.
module ssb_sync_gen
  import ssb_gen_pkg::*;
#(
  parameter int OUT_DW = 32,
  parameter int NFFT   = 256,
  parameter int AMP    = 2 ** (OUT_DW / 2 - 2)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [8:0]        N_id_1_i,
  input  logic [1:0]        N_id_2_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              error_o,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic [1:0]        m_axis_out_tuser,
  output logic [1:0]        dbg_state_o
);

  localparam int HW   = OUT_DW / 2;
  localparam int BW   = $clog2(NFFT);
  localparam int HALF = SSB_SC / 2;

  localparam logic [BW-1:0] BIN_LO   = BW'(HALF);
  localparam logic [BW-1:0] BIN_HI   = BW'(NFFT - HALF);
  localparam logic [BW-1:0] BIN_LAST = BW'(NFFT - 1);
  localparam logic [7:0]    K_LO     = 8'(SEQ_START);
  localparam logic [7:0]    K_HI     = 8'(SEQ_START + SEQ_LEN - 1);
  localparam logic [HW-1:0] AMP_POS  = HW'(AMP);
  localparam logic [HW-1:0] AMP_NEG  = HW'(-AMP);

`ifdef SSB_GEN_FULL_BLOCK_EN
  localparam logic [1:0] SYM_LAST = 2'd3;
  localparam logic [1:0] SYM_STEP = 2'd1;
`else
  localparam logic [1:0] SYM_LAST = 2'd2;
  localparam logic [1:0] SYM_STEP = 2'd2;
`endif

  ssb_state_e r_state, w_state_next;

  logic [6:0]        r_cnt;
  logic [8:0]        r_n1;
  logic [1:0]        r_n2;
  logic [6:0]        r_pss_sh, r_m0, r_m1;
  logic [126:0]      r_pss, r_sss0, r_sss1;
  logic [BW-1:0]     r_bin;
  logic [1:0]        r_sym;
  logic              r_issued;
  logic              r_valid, r_last, r_error;
  logic [OUT_DW-1:0] r_data;
  logic [1:0]        r_user;

  logic w_ids_ok, w_accept, w_gen, w_load, w_final_hs;
  logic w_pss_bit, w_sss0_bit, w_sss1_bit;

  assign w_ids_ok   = (N_id_1_i <= 9'(N_ID_1_MAX)) && (N_id_2_i <= 2'd2);
  assign w_accept   = (r_state == ST_IDLE) && start_i && w_ids_ok;
  assign w_gen      = (r_state == ST_GEN);
  assign w_final_hs = r_valid && m_axis_out_tready && r_last && (r_user == SYM_LAST);
  // The output register refills on the same edge it drains, so bins stream gap-free.
  assign w_load     = (r_state == ST_STREAM) && !r_issued && (!r_valid || m_axis_out_tready);

  m_seq_lfsr #(.TAPS(PSS_TAPS), .INIT(PSS_INIT)) u_lfsr_pss (
    .i_clk(clk_i), .i_rst(reset_i), .i_load(w_accept), .i_en(w_gen), .o_bit(w_pss_bit)
  );
  m_seq_lfsr #(.TAPS(SSS0_TAPS), .INIT(SSS0_INIT)) u_lfsr_sss0 (
    .i_clk(clk_i), .i_rst(reset_i), .i_load(w_accept), .i_en(w_gen), .o_bit(w_sss0_bit)
  );
  m_seq_lfsr #(.TAPS(SSS1_TAPS), .INIT(SSS1_INIT)) u_lfsr_sss1 (
    .i_clk(clk_i), .i_rst(reset_i), .i_load(w_accept), .i_en(w_gen), .o_bit(w_sss1_bit)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = ST_GEN;
      ST_GEN:    if (r_cnt == 7'(SEQ_LEN - 1)) w_state_next = ST_STREAM;
      ST_STREAM: if (w_final_hs) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // m0/m1 from N_id_1 using range compares in place of a divide by 112.
  logic [6:0] w_q15, w_n2x5, w_m0, w_m1, w_pss_sh;
  logic [8:0] w_sub, w_m1_full;
  always_comb begin
    w_q15 = 7'd0;
    w_sub = 9'd0;
    if (r_n1 >= 9'd224) begin
      w_q15 = 7'd30;
      w_sub = 9'd224;
    end else if (r_n1 >= 9'd112) begin
      w_q15 = 7'd15;
      w_sub = 9'd112;
    end
    w_n2x5    = (r_n2 == 2'd2) ? 7'd10 : ((r_n2 == 2'd1) ? 7'd5 : 7'd0);
    w_m0      = w_q15 + w_n2x5;
    w_m1_full = r_n1 - w_sub;
    w_m1      = w_m1_full[6:0];
    w_pss_sh  = (N_id_2_i == 2'd2) ? 7'd86 : ((N_id_2_i == 2'd1) ? 7'd43 : 7'd0);
  end

  logic [7:0]    w_k;
  logic          w_in_band, w_seq_sc, w_on, w_bit;
  logic [6:0]    w_n, w_idx_p, w_idx_0, w_idx_1;
  logic [HW-1:0] w_real;
  always_comb begin
    w_k       = 8'd0;
    w_in_band = 1'b0;
    w_on      = 1'b0;
    w_bit     = 1'b0;
    if (r_bin < BIN_LO) begin
      w_k       = 8'(r_bin) + 8'(HALF);
      w_in_band = 1'b1;
    end else if (r_bin >= BIN_HI) begin
      w_k       = 8'(r_bin - BIN_HI);
      w_in_band = 1'b1;
    end
    w_seq_sc = w_in_band && (w_k >= K_LO) && (w_k <= K_HI);
    w_n      = 7'(w_k - K_LO);
    w_idx_p  = mod127({1'b0, w_n} + {1'b0, r_pss_sh});
    w_idx_0  = mod127({1'b0, w_n} + {1'b0, r_m0});
    w_idx_1  = mod127({1'b0, w_n} + {1'b0, r_m1});
    if (w_seq_sc && (r_sym == 2'd0)) begin
      w_on  = 1'b1;
      w_bit = r_pss[w_idx_p];
    end else if (w_seq_sc && (r_sym == 2'd2)) begin
      w_on  = 1'b1;
      w_bit = r_sss0[w_idx_0] ^ r_sss1[w_idx_1];
    end
    w_real = w_on ? (w_bit ? AMP_NEG : AMP_POS) : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt    <= '0;
      r_n1     <= '0;
      r_n2     <= '0;
      r_pss_sh <= '0;
      r_m0     <= '0;
      r_m1     <= '0;
      r_pss    <= '0;
      r_sss0   <= '0;
      r_sss1   <= '0;
      r_bin    <= '0;
      r_sym    <= '0;
      r_issued <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_user   <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= (r_state == ST_IDLE) && start_i && !w_ids_ok;
      if (w_accept) begin
        r_n1     <= N_id_1_i;
        r_n2     <= N_id_2_i;
        r_pss_sh <= w_pss_sh;
        r_cnt    <= '0;
        r_bin    <= '0;
        r_sym    <= '0;
        r_issued <= 1'b0;
      end
      if (w_gen) begin
        r_cnt  <= r_cnt + 7'd1;
        r_pss  <= {w_pss_bit, r_pss[126:1]};
        r_sss0 <= {w_sss0_bit, r_sss0[126:1]};
        r_sss1 <= {w_sss1_bit, r_sss1[126:1]};
        r_m0   <= w_m0;
        r_m1   <= w_m1;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= {{HW{1'b0}}, w_real};
        r_last  <= (r_bin == BIN_LAST);
        r_user  <= r_sym;
        if (r_bin == BIN_LAST) begin
          r_bin <= '0;
          if (r_sym == SYM_LAST) r_issued <= 1'b1;
          else                   r_sym    <= r_sym + SYM_STEP;
        end else begin
          r_bin <= r_bin + BW'(1);
        end
      end else if (r_valid && m_axis_out_tready) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_last  <= 1'b0;
        r_user  <= '0;
      end
    end
  end

  assign busy_o            = (r_state != ST_IDLE);
  assign error_o           = r_error;
  assign m_axis_out_tdata  = r_data;
  assign m_axis_out_tvalid = r_valid;
  assign m_axis_out_tlast  = r_last;
  assign m_axis_out_tuser  = r_user;
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_ssb_sync_gen.sv
// Bench for ssb_sync_gen: sequence model built from the LFSR recurrences,
// expected beats queued at start, a negedge monitor pops and compares.
module tb_ssb_sync_gen;

  localparam int OUT_DW = 32;
  localparam int NFFT   = 256;
  localparam int AMP    = 2 ** (OUT_DW / 2 - 2);
  localparam int W      = 2 + 1 + OUT_DW;
`ifdef SSB_GEN_FULL_BLOCK_EN
  localparam int NSYM = 4;
  localparam int SSS_POS = 2;
`else
  localparam int NSYM = 2;
  localparam int SSS_POS = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_i;
  logic [8:0]        n1;
  logic [1:0]        n2;
  logic              start_i;
  logic              busy_o, error_o;
  logic [OUT_DW-1:0] tdata;
  logic              tvalid, tlast;
  logic              tready = 1'b1;
  logic [1:0]        tuser, dbg_state;

  int total = 0;
  int bad   = 0;
  int beat_cnt = 0;
  int ready_mode = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] beats[$];
  logic [W-1:0] ref_beats[$];

  int xs[127], x0s[127], x1s[127];

  ssb_sync_gen #(.OUT_DW(OUT_DW), .NFFT(NFFT)) dut (
    .clk_i(clk), .reset_i(reset_i), .N_id_1_i(n1), .N_id_2_i(n2), .start_i(start_i),
    .busy_o(busy_o), .error_o(error_o), .m_axis_out_tdata(tdata),
    .m_axis_out_tvalid(tvalid), .m_axis_out_tready(tready), .m_axis_out_tlast(tlast),
    .m_axis_out_tuser(tuser), .dbg_state_o(dbg_state)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // reference model
  task automatic build_seqs();
    int init_p[7] = '{0, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      xs[i]  = init_p[i];
      x0s[i] = (i == 0) ? 1 : 0;
      x1s[i] = (i == 0) ? 1 : 0;
    end
    for (int i = 0; i < 120; i++) begin
      xs[i+7]  = (xs[i+4] + xs[i]) % 2;
      x0s[i+7] = (x0s[i+4] + x0s[i]) % 2;
      x1s[i+7] = (x1s[i+1] + x1s[i]) % 2;
    end
  endtask

  task automatic push_model(input int id1, input int id2);
    int m0, m1, sym, k, nn, bitv, rv;
    logic [15:0] r16;
    logic [1:0]  u2;
    m0 = 15 * (id1 / 112) + 5 * id2;
    m1 = id1 % 112;
    for (int s = 0; s < NSYM; s++) begin
      sym = (NSYM == 4) ? s : 2 * s;
      for (int b = 0; b < NFFT; b++) begin
        k = -1;
        if (b < 120) k = b + 120;
        else if (b >= NFFT - 120) k = b - (NFFT - 120);
        rv = 0;
        if (k >= 56 && k <= 182 && (sym == 0 || sym == 2)) begin
          nn = k - 56;
          if (sym == 0) bitv = xs[(nn + 43 * id2) % 127];
          else          bitv = x0s[(nn + m0) % 127] ^ x1s[(nn + m1) % 127];
          rv = bitv ? -AMP : AMP;
        end
        r16 = 16'(rv);
        u2  = 2'(sym);
        exp_q.push_back({u2, (b == NFFT - 1), 16'h0000, r16});
      end
    end
  endtask

  // tready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor / scoreboard
  initial begin
    logic [W-1:0] cur, prev_beat;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      cur = {tuser, tlast, tdata};
      if (reset_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("hold_stable", {28'd0, tvalid, cur}, {28'd0, 1'b1, prev_beat});
        if (tvalid && tready) begin
          beat_cnt++;
          beats.push_back(cur);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat act=%0h req=none", cur);
          end else begin
            check("beat", cur, exp_q.pop_front());
          end
        end
        prev_stall = tvalid && !tready;
        prev_beat  = cur;
      end
    end
  end

  // driver tasks (all entered and left at posedge+1)
  task automatic start_ssb(input int id1, input int id2);
    push_model(id1, id2);
    beats.delete();
    n1 = 9'(id1);
    n2 = 2'(id2);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("busy_rise", busy_o, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    while (busy_o && c < max_cyc) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("idle_reached", busy_o, 0);
    check("queue_drained", exp_q.size(), 0);
    check("tvalid_low_idle", tvalid, 0);
  endtask

  task automatic reject(input int id1, input int id2);
    logic nv;
    n1 = 9'(id1);
    n2 = 2'(id2);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("err_pulse", error_o, 1);
    check("err_busy", busy_o, 0);
    @(posedge clk);
    #1;
    check("err_clear", error_o, 0);
    nv = 1'b1;
    repeat (10) begin
      if (tvalid || busy_o) nv = 1'b0;
      @(posedge clk);
      #1;
    end
    check("err_no_stream", nv, 1);
  endtask

  initial begin
    int lat, zero_bad, nlast, diff, base, c, a, b;
    logic [W-1:0] e;
    build_seqs();
    reset_i = 1'b1;
    start_i = 1'b0;
    n1 = '0;
    n2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_error", error_o, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    reset_i = 1'b0;
    @(posedge clk);
    #1;

    // ids 0/0 at full rate: latency and fixed spot values
    start_ssb(0, 0);
    lat = 0;
    while (!tvalid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("first_valid_latency", lat, 128);
    wait_idle(4000);
    e = beats[192];
    check("pss_bin192", e[15:0], 16'(AMP));
    zero_bad = 0;
    for (int i = 120; i < 136; i++) begin
      e = beats[i];
      if (e[OUT_DW-1:0] != 0) zero_bad++;
    end
    check("guard_bins_zero", zero_bad, 0);
    e = beats[SSS_POS * NFFT + 192];
    check("sss_bin192", e[15:0], 16'(AMP));

    // ids 335/2 at full rate, then replayed under random backpressure
    start_ssb(335, 2);
    wait_idle(4000);
    nlast = 0;
    foreach (beats[i]) if (beats[i][OUT_DW]) nlast++;
    check("tlast_count", nlast, NSYM);
    check("beat_total", beats.size(), NSYM * NFFT);
    ref_beats = beats;
    ready_mode = 1;
    start_ssb(335, 2);
    wait_idle(8000);
    check("replay_size", beats.size(), ref_beats.size());
    diff = 0;
    foreach (beats[i]) if (i < ref_beats.size() && beats[i] != ref_beats[i]) diff++;
    check("replay_equal", diff, 0);
    ready_mode = 0;

    // rejected starts
    reject(336, 0);
    reject(0, 3);
    reject(511, 3);

    // start while streaming is ignored; back-to-back start accepted
    start_ssb(17, 1);
    repeat (300) @(posedge clk);
    #1;
    n1 = 9'd5;
    n2 = 2'd0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("busy_start_no_err", error_o, 0);
    check("busy_start_busy", busy_o, 1);
    wait_idle(4000);
    start_ssb(100, 2);
    wait_idle(4000);

    // reset at SSS bin 100
    base = beat_cnt;
    start_ssb(200, 1);
    c = 0;
    while ((beat_cnt - base) < SSS_POS * NFFT + 100 && c < 4000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("reached_sss_bin100", (beat_cnt - base) >= SSS_POS * NFFT + 100, 1);
    #2;
    reset_i = 1'b1;
    #1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_tdata", tdata, 0);
    check("mid_rst_tlast", tlast, 0);
    check("mid_rst_tuser", tuser, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    start_ssb(42, 0);
    wait_idle(4000);

    // random ids and backpressure
    for (int r = 0; r < 4; r++) begin
      a = $urandom_range(0, 335);
      b = $urandom_range(0, 2);
      ready_mode = $urandom_range(0, 1);
      start_ssb(a, b);
      wait_idle(8000);
    end
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssb_sync_gen.md
# ssb_sync_gen

Transmit-side generator for the NR synchronisation signal block. It builds the PSS and SSS BPSK sequences for a requested cell identity and streams them as frequency-domain samples in FFT-bin order, ready for an IFFT and CP insertion. It is the loopback and test source for the PSS detector, SSS detector and FFT demodulator chain.

## Interface
- `OUT_DW`, 32: complex sample width; real part in `[OUT_DW/2-1:0]`, imag in `[OUT_DW-1:OUT_DW/2]`, both signed.
- `NFFT`, 256: IFFT size; power of two, ≥ 256.
- `AMP`, 2^(OUT_DW/2-2): BPSK magnitude written to the real part.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; asynchronous, active-high.
- `N_id_1_i`  in  9  SSS group id, 0..335.
- `N_id_2_i`  in  2  PSS id, 0..2.
- `start_i`  in  1  start request; sampled only in IDLE.
- `busy_o`  out  1  high from the accepting edge until the final handshake.
- `error_o`  out  1  one-cycle pulse on a rejected start.
- `m_axis_out_tdata`  out  OUT_DW  frequency-domain sample.
- `m_axis_out_tvalid`  out  1  sample valid.
- `m_axis_out_tready`  in  1  downstream ready.
- `m_axis_out_tlast`  out  1  high on bin NFFT-1 of each symbol.
- `m_axis_out_tuser`  out  2  symbol index within the SSB (0..3).

## Operation
- States: IDLE → GEN → STREAM → IDLE.
- **IDLE**
  - `start_i`=1 with `N_id_1_i`≤335 and `N_id_2_i`≤2: latch both ids, clear the LFSR counter, go to GEN.
  - Out-of-range ids: pulse `error_o` and stay in IDLE.
- **GEN**, 127 cycles. Three 7-bit LFSRs each shift one bit per cycle into a 127-bit sequence register:
  - PSS: x(i+7)=x(i+4)^x(i), with [x6..x0]=1110110.
  - SSS x0: x(i+7)=x(i+4)^x(i), with [x6..x0]=0000001.
  - SSS x1: x(i+7)=x(i+1)^x(i), with [x6..x0]=0000001.
  - Also computed in GEN: m0 = 15·floor(N_id_1/112) + 5·N_id_2, with the floor done by comparisons, no divider; m1 = N_id_1 mod 112.
- **STREAM**: bins b=0..NFFT-1 for each symbol in turn.
  - Bin to subcarrier: k = b+120 for b<120; k = b-(NFFT-120) for b≥NFFT-120; other bins output zero.
  - Subcarriers k=56..182 carry sequence index n=k-56. All other k output zero.
  - Symbol 0 (PSS): bit x((n+43·N_id_2) mod 127).
  - Symbol 2 (SSS): bit x0((n+m0) mod 127) XOR x1((n+m1) mod 127).
  - Mapping: bit 0 → real=+AMP, bit 1 → real=−AMP; imag is always 0.
  - All mod-127 additions use 8-bit sums followed by a conditional subtract of 127.
- After the tlast handshake of the final symbol: return to IDLE.
- `start_i` while busy is ignored; no error is raised.

## Timing
- Reset values: `busy_o`=0, `error_o`=0, `m_axis_out_tvalid`=0, `m_axis_out_tlast`=0, `m_axis_out_tdata`=0, `m_axis_out_tuser`=0; state is IDLE.
- Reset mid-operation clears the outputs immediately and aborts the SSB. No partial symbol is resumed.
- `busy_o` rises on the accepting edge.
- First `tvalid` goes high 128 cycles after the accepting edge: 127 GEN cycles plus 1 output register.
- AXI-stream rules:
  - A beat transfers when `tvalid & tready`.
  - While `tvalid & !tready`, `tdata`, `tlast` and `tuser` are held stable.
  - `tvalid` never deasserts mid-SSB.
- At full throughput: one bin per cycle and no gap between symbols.
- `busy_o` falls on the edge after the final handshake. A new start is accepted from the following cycle.
- `error_o` pulses on the edge after the rejected start.

## Configuration
- `SSB_GEN_FULL_BLOCK_EN` defined: four symbols, `tuser` 0,1,2,3.
  - Symbol 0 = PSS, symbol 2 = SSS.
  - Symbols 1 and 3 are all-zero PBCH placeholders with full NFFT bins and tlast.
- Not defined: two symbols only, PSS with `tuser`=0 then SSS with `tuser`=2.

## Structure
- Package `ssb_gen_pkg` holds:
  - constants `SSB_SC`=240, `SEQ_LEN`=127, `SEQ_START`=56, `N_ID_1_MAX`=335;
  - LFSR tap masks and init vectors;
  - the state enum type.
- Sub-module `m_seq_lfsr` (7-bit, parameterised tap mask and init), instantiated three times.

## Test plan
- N_id_1=0, N_id_2=0, NFFT=256, `tready`=1: first `tvalid` 128 cycles after start. PSS bin 192 (n=0) real=+AMP. Bins 120..135 are 0. All 256 PSS and SSS bins match the 38.211 Python model. SSS bin 192 real=+AMP.
- N_id_1=335, N_id_2=2: m0=40, m1=111. Both symbols match the model bit-exactly. `tlast` only on bin 255, `tuser` sequence correct for the compiled macro setting.
- Random `tready` toggling at 50 %: the output sequence equals the `tready`=1 run. Data is stable while stalled; no beats are dropped or duplicated.
- N_id_1=336, or N_id_2=3: one-cycle `error_o`, `busy_o` stays 0, no `tvalid`.
- Second start in the middle of STREAM: ignored and the stream completes unchanged. A start one cycle after `busy_o` falls is accepted.
- Assert reset at bin 100 of SSS: outputs are 0 the same cycle. A restart after reset produces a complete, correct SSB.
